// File: rtl/dm_cache_ctrl_if.sv
// CPU-side request/response and main-memory access signals of the direct-mapped cache.
// slave = cache controller, master = CPU plus main memory around it.
interface dm_cache_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  flush;
    logic                  cpu_busy;
    logic                  cpu_ready;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_hit;
    logic                  mem_req;
    logic                  mem_mode;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_flag;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_flag,
        output cpu_busy, cpu_ready, cpu_rdata, cpu_hit, mem_req, mem_mode, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_flag,
        input  cpu_busy, cpu_ready, cpu_rdata, cpu_hit, mem_req, mem_mode, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller, one word per line.
// Read hits are served locally; read misses and all writes go to main memory.
module dm_cache_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dm_cache_ctrl_if.slave       bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MEM_RD, S_MEM_WR, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    hit_q, hit_d;
    logic [CNT_WIDTH-1:0]    hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0]    mcnt_q, mcnt_d;

    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [DATA_WIDTH-1:0]   data_q [LINES];

    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_W-1:0]        tag;
    logic                    lookup_hit;
    logic                    line_we;
    logic                    line_fill;
    logic [DATA_WIDTH-1:0]   line_wdata;

    assign idx        = addr_q[INDEX_BITS-1:0];
    assign tag        = addr_q[ADDR_WIDTH-1:INDEX_BITS];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        hit_d      = hit_q;
        hcnt_d     = hcnt_q;
        mcnt_d     = mcnt_q;
        line_we    = 1'b0;
        line_fill  = 1'b0;
        line_wdata = wdata_q;
        case (state_q)
            S_IDLE: begin
                // flush and a same-edge request both act; the lookup sees the cleared array
                if (bus.flush) valid_d = '0;
                if (bus.cpu_req) begin
                    we_d    = bus.cpu_we;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!we_q) begin
                    if (lookup_hit) begin
                        rdata_d = data_q[idx];
                        hit_d   = 1'b1;
                        hcnt_d  = (hcnt_q == '1) ? hcnt_q : hcnt_q + 1'b1;
                        state_d = S_RESP;
                    end else begin
                        mcnt_d  = (mcnt_q == '1) ? mcnt_q : mcnt_q + 1'b1;
                        state_d = S_MEM_RD;
                    end
                end else begin
                    // write-through: refresh a hit line, never allocate on a miss
                    line_we = lookup_hit;
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                if (bus.mem_flag) begin
                    line_we      = 1'b1;
                    line_fill    = 1'b1;
                    line_wdata   = bus.mem_rdata;
                    valid_d[idx] = 1'b1;
                    rdata_d      = bus.mem_rdata;
                    hit_d        = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_MEM_WR: begin
                if (bus.mem_flag) begin
                    hit_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            hcnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            hcnt_q  <= hcnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

    // Tag/data storage carries no reset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[idx] <= line_wdata;
            if (line_fill) tag_q[idx] <= tag;
        end
    end

    assign bus.cpu_busy  = (state_q != S_IDLE);
    assign bus.cpu_ready = (state_q == S_RESP);
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_hit   = hit_q;
    assign bus.mem_req   = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign bus.mem_mode  = (state_q == S_MEM_WR);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign hit_count     = hcnt_q;
    assign miss_count    = mcnt_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Randomized bench for dm_cache_ctrl against a line-level cache model plus a word memory.
// Counters are built 4 bits wide so saturation is reached within the run.
module tb_dm_cache_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] hit_count, miss_count;

    dm_cache_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dm_cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_BITS(4), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: 16 lines, word memory, counters
    bit          m_valid [16];
    logic [27:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic [31:0] mem     [logic [31:0]];
    int          m_hits, m_misses;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a * 32'h9E37_79B1 + 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = 0; m_misses = 0; m_rdata = '0;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.flush = 1'b0; bus.mem_flag = 1'b0; bus.mem_rdata = '0;
    endtask

    // One CPU transaction; memory answers with mem_flag in the (dly+1)th mem_req cycle.
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input bit fl, input int dly);
        bit          hit, got;
        int          idx, lat, exp_lat, ncyc;
        logic [27:0] tg;
        logic [31:0] fill;
        @(negedge clk);
        chk("idle_busy", bus.cpu_busy, 1'b0);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.flush = fl;
        if (fl) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        idx  = int'(addr[3:0]);
        tg   = addr[31:4];
        hit  = m_valid[idx] && (m_tag[idx] == tg);
        fill = mem_rd(addr);
        if (!we) begin
            if (hit) begin
                m_rdata = m_data[idx];
                m_hits  = (m_hits == CMAX) ? CMAX : m_hits + 1;
                exp_lat = 2;
            end else begin
                m_rdata = fill;
                m_misses = (m_misses == CMAX) ? CMAX : m_misses + 1;
                m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = fill;
                exp_lat = 3 + dly;
            end
        end else begin
            if (hit) m_data[idx] = wd;
            mem[addr] = wd;
            exp_lat = 3 + dly;
        end
        @(posedge clk);
        lat = 1; ncyc = 0; got = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            #1;
            if (bus.cpu_ready) begin
                got = 1'b1;
                bus.cpu_req = 1'b0; bus.flush = 1'b0; bus.mem_flag = 1'b0;
            end else begin
                // inputs while busy must be ignored
                bus.cpu_req   = 1'($urandom_range(0, 1));
                bus.flush     = ($urandom_range(0, 3) == 0);
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = $urandom;
                bus.cpu_wdata = $urandom;
                if (bus.mem_req) begin
                    ncyc++;
                    chk("mem_mode", bus.mem_mode, we);
                    chk("mem_addr", bus.mem_addr, addr);
                    if (we) chk("mem_wdata", bus.mem_wdata, wd);
                    bus.mem_flag  = (ncyc == dly + 1);
                    bus.mem_rdata = (ncyc == dly + 1) ? fill : $urandom;
                end else begin
                    bus.mem_flag  = ($urandom_range(0, 3) == 0);
                    bus.mem_rdata = $urandom;
                end
                @(posedge clk);
                lat++;
            end
        end
        chk("ready_seen", got, 1'b1);
        chk("latency", lat, exp_lat);
        chk("mem_cycles", ncyc, (!we && hit) ? 0 : dly + 1);
        chk("cpu_hit", bus.cpu_hit, !we && hit);
        chk("cpu_rdata", bus.cpu_rdata, m_rdata);
        @(posedge clk);
        #1;
        chk("ready_pulse", bus.cpu_ready, 1'b0);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
    endtask

    task automatic reset_mid_read();
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd100; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.flush = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_memreq", bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_memreq", bus.mem_req, 1'b0);
        chk("rst_busy", bus.cpu_busy, 1'b0);
        chk("rst_ready", bus.cpu_ready, 1'b0);
        chk("rst_misses", miss_count, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        bus.mem_flag = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_no_ready", bus.cpu_ready, 1'b0);
        end
        bus.mem_flag = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [31:0] a;
        idle_inputs();
        model_reset();
        mem[32'd100] = 32'd14528;
        #12;
        chk("reset_busy", bus.cpu_busy, 1'b0);
        chk("reset_ready", bus.cpu_ready, 1'b0);
        chk("reset_memreq", bus.mem_req, 1'b0);
        chk("reset_rdata", bus.cpu_rdata, 0);
        chk("reset_hits", hit_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        txn(0, 32'd100, 0, 0, 3);
        txn(0, 32'd100, 0, 0, 0);
        txn(1, 32'd100, 32'd25, 0, 1);
        txn(0, 32'd100, 0, 0, 0);
        txn(1, 32'd116, 32'd7, 0, 2);
        txn(0, 32'd116, 0, 0, 1);
        txn(0, 32'd116, 0, 0, 0);
        txn(0, 32'd100, 0, 0, 0);
        txn(0, 32'd116, 0, 0, 2);
        txn(0, 32'd100, 0, 0, 1);
        txn(0, 32'd100, 0, 1, 0);
        reset_mid_read();
        txn(0, 32'd100, 0, 0, 2);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'd100;
                1:       a = 32'd116;
                default: a = $urandom_range(0, 63);
            endcase
            txn(($urandom_range(0, 2) == 0), a, $urandom, ($urandom_range(0, 15) == 0),
                $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
